// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared processor-side constants and types used by the boot-time program
// loader and the instruction memory it fills.
//   IMEM_DEPTH     : number of 32-bit words in InstructionMemory
//   LOADER_DEPTH   : default number of words the loader may write
//   loader_state_t : loader FSM encoding (IDLE=0, RECV=1, WRITE=2, DONE=3)
//   word_to_byte_addr() : word index -> byte address (index x 4)
// -----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int IMEM_DEPTH   = 32;
    localparam int LOADER_DEPTH = IMEM_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    function automatic logic [31:0] word_to_byte_addr(input logic [29:0] index);
        return {index, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Bundles the loader's control, byte-stream and instruction-memory signals.
//   start, len_words        : load request and requested word count
//   byte_valid, byte_data   : byte source -> loader
//   byte_ready              : loader -> byte source (accept this cycle)
//   imem_we/addr/wdata      : loader -> instruction memory write port
//   cpu_hold, busy, done    : loader status towards the processor / system
// Modports: master = source / system side, slave = the loader itself.
// -----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int LEN_W = 6
);
    logic             start;
    logic [LEN_W-1:0] len_words;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;

    modport master (
        output start, len_words, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done
    );

    modport slave (
        input  start, len_words, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done
    );
endinterface

// File: rtl/program_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles four bytes into one little-endian 32-bit word: the first byte
// shifted in ends up in [7:0], the fourth in [31:24].
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous restart (drop any partial word)
//   shift_en   : a byte transfer happens this cycle
//   byte_data  : byte payload
//   word       : assembled word (complete after the fourth shift)
//   last       : this transfer is the fourth byte of the word
// -----------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] count;

    assign last = shift_en && (count == 2'd3);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            // Shifting right places the oldest byte in the low lane after four
            // transfers; count wraps to 0 on the fourth.
            word  <= {byte_data, word[31:8]};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a program as a byte stream and writes it word by word into the
// instruction memory while holding the processor in reset.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : program_loader_if.slave (start/len_words, byte stream with
//           valid/ready, imem write port, cpu_hold/busy/done)
// Parameters:
//   DEPTH : maximum number of words written; longer requests are clamped
//   LEN_W : width of len_words (must hold 0..DEPTH)
// All outputs decode from the FSM state and registers only.
// -----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH = LOADER_DEPTH,
    parameter int LEN_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus
);

    loader_state_t    state;
    loader_state_t    state_next;
    logic [LEN_W-1:0] index;
    logic [LEN_W-1:0] length;
    logic [LEN_W-1:0] clamped_len;

    logic             start_accept;
    logic             xfer;
    logic             word_last;
    logic [31:0]      word;

    logic             byte_ready;
    logic             imem_we;
    logic             busy;
    logic             done;

    assign clamped_len  = (bus.len_words > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len_words;
    assign start_accept = (state == ST_IDLE) && bus.start;
    assign xfer         = bus.byte_valid && byte_ready;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_accept),
        .shift_en  (xfer),
        .byte_data (bus.byte_data),
        .word      (word),
        .last      (word_last)
    );

    // State, load length and word index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            index  <= '0;
            length <= '0;
        end else begin
            state <= state_next;
            if (start_accept) begin
                length <= clamped_len;
                index  <= '0;
            end else if (state == ST_WRITE && state_next == ST_RECV) begin
                index <= index + LEN_W'(1);
            end
        end
    end

    // Next state and state-decoded outputs.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = (clamped_len == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && word_last) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                imem_we    = 1'b1;
                busy       = 1'b1;
                // length >= 1 whenever WRITE is reachable.
                state_next = (index == length - LEN_W'(1)) ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.byte_ready = byte_ready;
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = word_to_byte_addr(30'(index));
    assign bus.imem_wdata = word;
    assign bus.busy       = busy;
    assign bus.cpu_hold   = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader: drives the byte source at the falling
// edge, logs writes and done pulses at the falling edge, and compares against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader_if #(.LEN_W(6)) bus ();

    program_loader #(.DEPTH(32), .LEN_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_count = 0;
    int          done_cyc   = 0;
    int          start_cyc  = 0;
    bit          busy_seen  = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_count = 0;
        busy_seen  = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after start is sampled.
    task automatic start_load(input logic [5:0] len);
        start_cyc     = cyc;
        bus.start     = 1'b1;
        bus.len_words = len;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Presents one byte and returns at the falling edge after it was taken.
    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            push_byte(w[8*k +: 8]);
            if (gaps) begin
                if (k != 3) check("ready_in_gap", 32'(bus.byte_ready), 32'd1);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_count == 0 && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (done_count == 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.len_words  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        reset          = 1'b1;

        // Reset values, during and after reset.
        repeat (2) @(negedge clk);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_imem_we",    32'(bus.imem_we),    32'd0);
        check("rst_cpu_hold",   32'(bus.cpu_hold),   32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy",  32'(bus.busy),       32'd0);
        check("post_rst_ready", 32'(bus.byte_ready), 32'd0);

        // Two words, gap-free.
        clear_log();
        start_load(6'd2);
        check("t1_busy",     32'(bus.busy),       32'd1);
        check("t1_cpu_hold", 32'(bus.cpu_hold),   32'd1);
        check("t1_ready",    32'(bus.byte_ready), 32'd1);
        push_word(32'h0000_0013, 1'b0);
        push_word(32'h0010_0093, 1'b0);
        wait_done();
        check("t1_writes", 32'(wr_addr.size()), 32'd2);
        check("t1_addr0",  wr_addr[0], 32'd0);
        check("t1_data0",  wr_data[0], 32'h0000_0013);
        check("t1_addr1",  wr_addr[1], 32'd4);
        check("t1_data1",  wr_data[1], 32'h0010_0093);
        check("t1_load_cycles", 32'(done_cyc - start_cyc + 1), 32'd12);
        check("t1_done_pulses", 32'(done_count), 32'd1);
        check("t1_idle_busy",   32'(bus.busy), 32'd0);

        // Zero-length load.
        clear_log();
        start_load(6'd0);
        wait_done();
        check("t2_writes",      32'(wr_addr.size()), 32'd0);
        check("t2_busy_seen",   32'(busy_seen), 32'd0);
        check("t2_load_cycles", 32'(done_cyc - start_cyc + 1), 32'd2);

        // Oversized request is clamped to DEPTH.
        clear_log();
        start_load(6'd40);
        for (int w = 0; w < 32; w++) begin
            push_word({8'(w*4+3), 8'(w*4+2), 8'(w*4+1), 8'(w*4)}, 1'b0);
        end
        wait_done();
        check("t3_writes",    32'(wr_addr.size()), 32'd32);
        check("t3_first",     wr_data[0], 32'h0302_0100);
        check("t3_last_addr", wr_addr[31], 32'd124);
        check("t3_last_data", wr_data[31], 32'h7F7E_7D7C);
        check("t3_ready_after", 32'(bus.byte_ready), 32'd0);

        // Same program as the first load, with a gap after every byte.
        clear_log();
        start_load(6'd2);
        push_word(32'h0000_0013, 1'b1);
        push_word(32'h0010_0093, 1'b1);
        wait_done();
        check("t4_writes", 32'(wr_addr.size()), 32'd2);
        check("t4_data0",  wr_data[0], 32'h0000_0013);
        check("t4_addr1",  wr_addr[1], 32'd4);
        check("t4_data1",  wr_data[1], 32'h0010_0093);

        // Reset after two bytes: partial word dropped, no write, no done.
        clear_log();
        start_load(6'd1);
        push_byte(8'hAA);
        push_byte(8'hBB);
        reset = 1'b1;
        #1;
        check("t5_busy",     32'(bus.busy),       32'd0);
        check("t5_cpu_hold", 32'(bus.cpu_hold),   32'd0);
        check("t5_ready",    32'(bus.byte_ready), 32'd0);
        check("t5_we",       32'(bus.imem_we),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_write", 32'(wr_addr.size()), 32'd0);
        check("t5_no_done",  32'(done_count), 32'd0);
        start_load(6'd1);
        push_word(32'h4433_2211, 1'b0);
        wait_done();
        check("t5_writes", 32'(wr_addr.size()), 32'd1);
        check("t5_addr",   wr_addr[0], 32'd0);
        check("t5_data",   wr_data[0], 32'h4433_2211);

        // Start pulses mid-load are ignored; the three-word load completes.
        clear_log();
        start_load(6'd3);
        push_word(32'hA3A2_A1A0, 1'b0);
        bus.start     = 1'b1;
        bus.len_words = 6'd1;
        @(negedge clk);
        bus.start     = 1'b0;
        push_byte(8'hB0);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        push_word(32'hC3C2_C1C0, 1'b0);
        wait_done();
        check("t6_writes", 32'(wr_addr.size()), 32'd3);
        check("t6_data1",  wr_data[1], 32'hB3B2_B1B0);
        check("t6_addr2",  wr_addr[2], 32'd8);
        check("t6_data2",  wr_data[2], 32'hC3C2_C1C0);
        check("t6_done_pulses", 32'(done_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
